mem_access_stage: RTL and testbench
===================================

# mem_access_stage

MEM-stage data-memory access unit of the five-stage MIPS pipeline, sitting directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register. It turns the registered EX/MEM load/store controls into a request/response transaction on the data bus. It stalls the pipeline while an access is outstanding, and sign- or zero-extends load data. It also flags address-error exceptions before any bus traffic is issued.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- exmem_mem_r  in  1  load in MEM
- exmem_mem_w  in  1  store in MEM
- mem_nop  in  1  MEM slot holds a bubble; suppresses any access
- exmem_alu_res  in  32  effective address
- exmem_aligned_rt_data  in  32  store data, already lane-aligned
- mem_byte_w_en  in  4  store byte strobes
- exmem_load_sel  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
- exmem_store_sel  in  3  0 SW, 1 SB, 2 SH
- exmem_excepttype  in  32  exception bits inherited from EX
- pipe_stall  in  1  stall raised by another stage; holds the MEM slot
- cu_flush  in  1  exception flush of the MEM slot
- dbus_req  out  1  request valid
- dbus_wr  out  1  1 = write
- dbus_addr  out  32  byte address
- dbus_wstrb  out  4  write strobes (0 for reads)
- dbus_wdata  out  32  write data
- dbus_addr_ok  in  1  request accepted
- dbus_data_ok  in  1  response / write-complete
- dbus_rdata  in  32  read data
- mem_stall  out  1  MEM cannot retire this cycle
- mem_load_data  out  32  extended load result, registered
- mem_excepttype_out  out  32  exmem_excepttype OR new bits: bit 4 = AdEL, bit 5 = AdES
- mem_badvaddr  out  32  faulting address, valid when bit 4 or bit 5 is set

## Operation
- access = (mem_r | mem_w) & !mem_nop & !cu_flush & (exmem_excepttype == 0) & !addr_err.
- addr_err:
  - LW/SW: addr[1:0] != 0.
  - LH/LHU/SH: addr[0] != 0.
  - Byte accesses never fault.
  - Combinational.
  - Sets bit 4 for a load or bit 5 for a store; mem_badvaddr = addr.
- State machine: IDLE, REQ, WAIT, DONE, DRAIN.
  - IDLE: dbus_req = access. On access & addr_ok, go to WAIT. On access & !addr_ok, go to REQ.
  - REQ: dbus_req = 1, with address, data and strobes held from EX/MEM. On addr_ok, go to WAIT. On cu_flush, go to IDLE and drop the request the same cycle.
  - WAIT: dbus_req = 0. On data_ok, go to DONE and capture the extended rdata into mem_load_data (writes leave it unchanged). If cu_flush arrives without data_ok, go to DRAIN. If cu_flush and data_ok arrive together, go to IDLE.
  - DONE: mem_stall = 0. On !pipe_stall, go to IDLE; otherwise hold. No re-issue while in DONE.
  - DRAIN: dbus_req = 0; wait for data_ok, discard the data, then go to IDLE. mem_stall = 1 throughout.
- mem_stall = (access & state ∈ {IDLE, REQ, WAIT}) | state == DRAIN.
- Load extension uses addr[1:0] to select the lane:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- dbus_addr = exmem_alu_res. Full byte address; no masking except as stated under Configuration.

## Timing
- Reset values:
  - State = IDLE.
  - dbus_req, dbus_wr, dbus_wstrb, dbus_wdata = 0.
  - mem_load_data = 0.
  - mem_stall = 0 (no access is possible out of reset because the EX/MEM outputs are reset).
- Reset in any state returns to IDLE next edge; an outstanding response is not tracked (bus shares reset).
- Best-case latency: addr_ok in cycle 0, data_ok in cycle 1, DONE in cycle 2, so two stall cycles.
- dbus_req, once high, stays high with stable payload until addr_ok (REQ state) unless flushed.
- One outstanding transaction maximum; no new request until DRAIN/DONE exits.
- Exception and address-error outputs are combinational, same cycle as the EX/MEM contents.

## Configuration
- MEM_ADDR_EXC_EN defined: alignment checking and the AdEL/AdES bits are as above.
- Undefined:
  - addr_err = 0.
  - dbus_addr[1:0] is forced to 0 for word accesses and dbus_addr[0] to 0 for halfword accesses.
  - mem_excepttype_out = exmem_excepttype.
  - mem_badvaddr = 0.

## Test plan
- LB at 0x0000_1003, rdata 0x80FF_FF7F, addr_ok cycle 0, data_ok cycle 1 -> mem_load_data = 0xFFFF_FF80; mem_stall high for exactly 2 cycles.
- SH at 0x0000_2002, wstrb 4'b1100, addr_ok delayed 3 cycles -> dbus_req high 4 cycles with payload stable; dbus_wr = 1; stall released in the cycle after data_ok.
- LW at 0x0000_3001 (macro defined) -> no dbus_req; mem_excepttype_out bit 4 = 1; mem_badvaddr = 0x0000_3001. With the macro undefined -> dbus_addr = 0x0000_3000.
- Flush in WAIT, data_ok 2 cycles later -> DRAIN, mem_stall = 1 until data_ok, mem_load_data unchanged, then IDLE with no re-issue.
- pipe_stall held 3 cycles in DONE -> single bus transaction only; mem_load_data stable; back to IDLE on release.
- Reset asserted in REQ -> next cycle state IDLE with dbus_req = 0 and mem_load_data = 0.

Source files
------------

// File: rtl/mem_access_stage.sv
//
// mem_access_stage
// ----------------
// Data-memory access unit for the MEM stage of the five-stage MIPS pipeline.
// It sits between the EX/MEM and MEM/WB registers. It turns the registered
// load/store controls into one request/response transaction on the data bus
// and stalls the pipeline while that transaction is outstanding. Load data is
// sign- or zero-extended into a registered result. Address-error exceptions
// are flagged before any bus traffic is issued.
//
// Build option:
//   MEM_ADDR_EXC_EN  defined   -> misaligned word/halfword accesses raise AdEL
//                                 (bit 4) or AdES (bit 5) and issue no request.
//                    undefined -> no alignment faults. The low address bits are
//                                 forced to zero for word/halfword accesses.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   exmem_mem_r / exmem_mem_w         load / store in the MEM slot
//   mem_nop                           MEM slot holds a bubble
//   exmem_alu_res                     effective byte address
//   exmem_aligned_rt_data             lane-aligned store data
//   mem_byte_w_en                     store byte strobes
//   exmem_load_sel                    0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU
//   exmem_store_sel                   0 SW, 1 SB, 2 SH
//   exmem_excepttype                  exception bits carried from EX
//   pipe_stall                        another stage is holding the MEM slot
//   cu_flush                          exception flush of the MEM slot
//   dbus_req/wr/addr/wstrb/wdata      data-bus request channel
//   dbus_addr_ok/data_ok/rdata        data-bus acceptance and response
//   mem_stall                         MEM cannot retire this cycle
//   mem_load_data                     registered, extended load result
//   mem_excepttype_out, mem_badvaddr  exception bits and faulting address
`timescale 1ns/1ps

module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        exmem_mem_r,
    input  logic        exmem_mem_w,
    input  logic        mem_nop,
    input  logic [31:0] exmem_alu_res,
    input  logic [31:0] exmem_aligned_rt_data,
    input  logic [3:0]  mem_byte_w_en,
    input  logic [2:0]  exmem_load_sel,
    input  logic [2:0]  exmem_store_sel,
    input  logic [31:0] exmem_excepttype,
    input  logic        pipe_stall,
    input  logic        cu_flush,
    output logic        dbus_req,
    output logic        dbus_wr,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_wstrb,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_addr_ok,
    input  logic        dbus_data_ok,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_load_data,
    output logic [31:0] mem_excepttype_out,
    output logic [31:0] mem_badvaddr
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_DRAIN} state_t;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;
    localparam logic [2:0] ST_SW  = 3'd0;
    localparam logic [2:0] ST_SH  = 3'd2;

    state_t      state, state_next;
    logic        word_acc, half_acc;
    logic        addr_err;
    logic        access;
    logic [31:0] bus_addr;

    // Little-endian lane select: bytes by addr[1:0], halfwords by addr[1].
    function automatic logic [31:0] extend_load(input logic [2:0]  sel,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sel)
            LD_LB:   return {{24{b[7]}}, b};
            LD_LBU:  return {24'd0, b};
            LD_LH:   return {{16{h[15]}}, h};
            LD_LHU:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    assign word_acc = (exmem_mem_r && exmem_load_sel == LD_LW) ||
                      (exmem_mem_w && exmem_store_sel == ST_SW);
    assign half_acc = (exmem_mem_r && (exmem_load_sel == LD_LH || exmem_load_sel == LD_LHU)) ||
                      (exmem_mem_w && exmem_store_sel == ST_SH);

`ifdef MEM_ADDR_EXC_EN
    // A bubble never faults; byte accesses are always aligned.
    assign addr_err = !mem_nop &&
                      ((word_acc && exmem_alu_res[1:0] != 2'b00) ||
                       (half_acc && exmem_alu_res[0]));
    assign bus_addr = exmem_alu_res;
    assign mem_excepttype_out = exmem_excepttype |
                                {26'd0, addr_err && exmem_mem_w, addr_err && exmem_mem_r, 4'd0};
    assign mem_badvaddr = addr_err ? exmem_alu_res : 32'd0;
`else
    assign addr_err = 1'b0;
    always_comb begin
        bus_addr = exmem_alu_res;
        if (word_acc)
            bus_addr[1:0] = 2'b00;
        else if (half_acc)
            bus_addr[0] = 1'b0;
    end
    assign mem_excepttype_out = exmem_excepttype;
    assign mem_badvaddr = 32'd0;
`endif

    assign access = (exmem_mem_r || exmem_mem_w) && !mem_nop && !cu_flush &&
                    (exmem_excepttype == 32'd0) && !addr_err;

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        dbus_req   = 1'b0;
        mem_stall  = 1'b0;
        case (state)
            S_IDLE: begin
                dbus_req  = access;
                mem_stall = access;
                if (access)
                    state_next = dbus_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                // Payload comes straight from EX/MEM, which the stall holds.
                dbus_req  = !cu_flush;
                mem_stall = access;
                if (cu_flush)
                    state_next = S_IDLE;
                else if (dbus_addr_ok)
                    state_next = S_WAIT;
            end
            S_WAIT: begin
                mem_stall = access;
                if (dbus_data_ok)
                    state_next = cu_flush ? S_IDLE : S_DONE;
                else if (cu_flush)
                    state_next = S_DRAIN;
            end
            S_DONE: begin
                // Result is ready; stay here without re-issuing while held.
                if (!pipe_stall)
                    state_next = S_IDLE;
            end
            S_DRAIN: begin
                // The bus still owes a response to a flushed access.
                mem_stall = 1'b1;
                if (dbus_data_ok)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign dbus_wr    = dbus_req && exmem_mem_w;
    assign dbus_addr  = bus_addr;
    assign dbus_wstrb = dbus_wr ? mem_byte_w_en : 4'd0;
    assign dbus_wdata = dbus_wr ? exmem_aligned_rt_data : 32'd0;

    always_ff @(posedge clk) begin
        if (reset)
            mem_load_data <= 32'd0;
        else if (state == S_WAIT && dbus_data_ok && !cu_flush && exmem_mem_r)
            mem_load_data <= extend_load(exmem_load_sel, exmem_alu_res[1:0], dbus_rdata);
    end

endmodule

// File: tb/tb_mem_access_stage.sv
//
// tb_mem_access_stage
// -------------------
// Randomised scoreboard bench for mem_access_stage. A driver process issues
// MEM-slot transactions and plays the data bus with chosen handshake delays.
// For every transaction it queues the bus request it expects and the
// completion it expects (load result and number of stall cycles). A monitor
// process samples on the falling edge and checks what the DUT presents
// against those queues and against a model of the exception outputs.
`timescale 1ns/1ps

module tb_mem_access_stage;

    logic        clk;
    logic        reset;
    logic        exmem_mem_r, exmem_mem_w, mem_nop;
    logic [31:0] exmem_alu_res, exmem_aligned_rt_data;
    logic [3:0]  mem_byte_w_en;
    logic [2:0]  exmem_load_sel, exmem_store_sel;
    logic [31:0] exmem_excepttype;
    logic        pipe_stall, cu_flush;
    logic        dbus_req, dbus_wr;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_addr_ok, dbus_data_ok;
    logic [31:0] dbus_rdata;
    logic        mem_stall;
    logic [31:0] mem_load_data, mem_excepttype_out, mem_badvaddr;

    mem_access_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .exmem_mem_r           (exmem_mem_r),
        .exmem_mem_w           (exmem_mem_w),
        .mem_nop               (mem_nop),
        .exmem_alu_res         (exmem_alu_res),
        .exmem_aligned_rt_data (exmem_aligned_rt_data),
        .mem_byte_w_en         (mem_byte_w_en),
        .exmem_load_sel        (exmem_load_sel),
        .exmem_store_sel       (exmem_store_sel),
        .exmem_excepttype      (exmem_excepttype),
        .pipe_stall            (pipe_stall),
        .cu_flush              (cu_flush),
        .dbus_req              (dbus_req),
        .dbus_wr               (dbus_wr),
        .dbus_addr             (dbus_addr),
        .dbus_wstrb            (dbus_wstrb),
        .dbus_wdata            (dbus_wdata),
        .dbus_addr_ok          (dbus_addr_ok),
        .dbus_data_ok          (dbus_data_ok),
        .dbus_rdata            (dbus_rdata),
        .mem_stall             (mem_stall),
        .mem_load_data         (mem_load_data),
        .mem_excepttype_out    (mem_excepttype_out),
        .mem_badvaddr          (mem_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] ld;
        int          stall;
    } res_t;

    req_t req_q[$];
    res_t res_q[$];

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] last_ld;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Access size in bytes from the opcode selector.
    function automatic int acc_size(input logic ld, input logic [2:0] sel);
        if (ld)
            return (sel == 3'd0) ? 4 : (sel == 3'd3 || sel == 3'd4) ? 2 : 1;
        return (sel == 3'd0) ? 4 : (sel == 3'd2) ? 2 : 1;
    endfunction

    // Extended load value computed arithmetically from the selected lane.
    function automatic logic [31:0] load_model(input logic [2:0] sel, input logic [31:0] addr,
                                               input logic [31:0] rdata);
        logic [31:0] v;
        case (sel)
            3'd1, 3'd2: begin
                v = (rdata >> (8 * addr[1:0])) & 32'h0000_00FF;
                if (sel == 3'd1 && v >= 32'd128) v = v - 32'd256;
            end
            3'd3, 3'd4: begin
                v = (rdata >> (16 * addr[1])) & 32'h0000_FFFF;
                if (sel == 3'd3 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic misaligned(input logic ld, input logic [2:0] sel,
                                        input logic [31:0] addr, input logic nop);
`ifdef MEM_ADDR_EXC_EN
        return !nop && ((addr % 32'(acc_size(ld, sel))) != 32'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exmem_mem_r = 1'b0; exmem_mem_w = 1'b0; mem_nop = 1'b0;
        exmem_alu_res = 32'd0; exmem_aligned_rt_data = 32'd0; mem_byte_w_en = 4'd0;
        exmem_load_sel = 3'd0; exmem_store_sel = 3'd0; exmem_excepttype = 32'd0;
        pipe_stall = 1'b0; cu_flush = 1'b0;
        dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; dbus_rdata = 32'd0;
    endtask

    // One MEM-slot instruction. a: cycles before addr_ok, d: cycles from
    // addr_ok to data_ok (>=1), p: cycles pipe_stall holds DONE,
    // f: flush f cycles after addr_ok (0 = no flush, 1..d).
    task automatic run_txn(input logic ld, input logic [2:0] sel, input logic [31:0] addr,
                           input logic [31:0] data, input logic nop, input logic [31:0] excp,
                           input int a, input int d, input int p, input int f);
        int          sz;
        logic        acc, flushed;
        logic [3:0]  strb;
        req_t        rq;
        res_t        rs;
        sz   = acc_size(ld, sel);
        strb = (sz == 4) ? 4'b1111 : (sz == 2) ? (addr[1] ? 4'b1100 : 4'b0011)
                                               : (4'b0001 << addr[1:0]);
        exmem_mem_r = ld; exmem_mem_w = !ld; mem_nop = nop;
        exmem_load_sel = ld ? sel : 3'd0; exmem_store_sel = ld ? 3'd0 : sel;
        exmem_alu_res = addr; exmem_aligned_rt_data = ld ? $urandom : data;
        mem_byte_w_en = ld ? 4'd0 : strb; exmem_excepttype = excp;
        acc = !nop && excp == 32'd0 && !misaligned(ld, sel, addr, nop);
        if (!acc) begin
            tick();
            tick();
            clear_inputs();
            return;
        end
        flushed = (f != 0);
`ifdef MEM_ADDR_EXC_EN
        rq.addr = addr;
`else
        rq.addr = addr & ~(32'(sz) - 32'd1);
`endif
        rq.wr = !ld; rq.strb = ld ? 4'd0 : strb; rq.wdata = data;
        req_q.push_back(rq);
        rs.ld    = (ld && !flushed) ? load_model(sel, addr, data) : last_ld;
        rs.stall = a + 1 + d - (flushed ? 1 : 0);
        last_ld  = rs.ld;
        res_q.push_back(rs);
        for (int c = 0; c <= a + d; c++) begin
            if (flushed && c > a + f) begin
                exmem_mem_r = 1'b0; exmem_mem_w = 1'b0; mem_nop = 1'b1;
            end
            dbus_addr_ok = (c == a);
            dbus_data_ok = (c == a + d);
            cu_flush     = flushed && (c == a + f);
            dbus_rdata   = (ld && c == a + d) ? data : $urandom;
            tick();
        end
        dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; cu_flush = 1'b0;
        if (!flushed) begin
            pipe_stall = 1'b1;
            repeat (p) tick();
            pipe_stall = 1'b0;
            tick();
        end
        clear_inputs();
    endtask

    // Monitor: falling-edge sampling of everything the DUT presents.
    initial begin
        logic [31:0] cur_ld, exp_exc, exp_bad;
        logic        prev_dok, mis;
        int          stall_cnt;
        req_t        rq;
        res_t        rs;
        cur_ld = 32'd0; prev_dok = 1'b0; stall_cnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                req_q.delete(); res_q.delete();
                cur_ld = 32'd0; prev_dok = 1'b0; stall_cnt = 0;
            end else begin
                mis = (exmem_mem_r || exmem_mem_w) &&
                      misaligned(exmem_mem_r, exmem_mem_r ? exmem_load_sel : exmem_store_sel,
                                 exmem_alu_res, mem_nop);
                exp_exc = exmem_excepttype | ((mis && exmem_mem_r) ? 32'h10 : 32'h0)
                                           | ((mis && exmem_mem_w) ? 32'h20 : 32'h0);
                exp_bad = mis ? exmem_alu_res : 32'd0;
                check32("excepttype_out", mem_excepttype_out, exp_exc);
                check32("badvaddr", mem_badvaddr, exp_bad);
                check32("dbus_req", 32'(dbus_req), 32'(req_q.size() != 0));
                if (dbus_req && req_q.size() != 0) begin
                    rq = req_q[0];
                    check32("dbus_addr", dbus_addr, rq.addr);
                    check32("dbus_wr", 32'(dbus_wr), 32'(rq.wr));
                    check32("dbus_wstrb", 32'(dbus_wstrb), 32'(rq.strb));
                    if (rq.wr) check32("dbus_wdata", dbus_wdata, rq.wdata);
                    if (dbus_addr_ok) void'(req_q.pop_front());
                end
                if (prev_dok) begin
                    if (res_q.size() == 0) begin
                        check32("result_queue_nonempty", 32'd0, 32'd1);
                    end else begin
                        rs = res_q.pop_front();
                        cur_ld = rs.ld;
                        check32("stall_cycles", 32'(stall_cnt), 32'(rs.stall));
                    end
                    stall_cnt = 0;
                end
                check32("mem_load_data", mem_load_data, cur_ld);
                stall_cnt += int'(mem_stall);
                prev_dok = dbus_data_ok;
            end
        end
    end

    // Driver
    initial begin
        logic        ld, nop;
        logic [2:0]  sel;
        logic [31:0] addr, excp;
        int          sz, kind, d, f;
        rq_init: begin end
        clear_inputs();
        last_ld = 32'd0;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // LB sign extension, best-case latency.
        run_txn(1'b1, 3'd1, 32'h0000_1003, 32'h80FF_FF7F, 1'b0, 32'd0, 0, 1, 0, 0);
        // SH with addr_ok three cycles late.
        run_txn(1'b0, 3'd2, 32'h0000_2002, 32'hBEEF_0000, 1'b0, 32'd0, 3, 1, 0, 0);
        // Misaligned LW: fault with the option on, masked address otherwise.
        run_txn(1'b1, 3'd0, 32'h0000_3001, 32'h1234_5678, 1'b0, 32'd0, 0, 1, 0, 0);
        // Flush in WAIT, response two cycles later.
        run_txn(1'b1, 3'd3, 32'h0000_5002, 32'h8001_1234, 1'b0, 32'd0, 0, 3, 0, 1);
        // DONE held by pipe_stall for three cycles.
        run_txn(1'b1, 3'd4, 32'h0000_6002, 32'h9ABC_5678, 1'b0, 32'd0, 0, 1, 3, 0);
        // Inherited exception and bubble suppress the access.
        run_txn(1'b1, 3'd0, 32'h0000_7000, 32'h1111_2222, 1'b0, 32'h0000_0400, 0, 1, 0, 0);
        run_txn(1'b0, 3'd0, 32'h0000_7004, 32'h3333_4444, 1'b1, 32'd0, 0, 1, 0, 0);

        for (int i = 0; i < 150; i++) begin
            ld   = 1'($urandom_range(0, 1));
            sel  = ld ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 2));
            sz   = acc_size(ld, sel);
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) addr = addr & ~(32'(sz) - 32'd1);
            kind = int'($urandom_range(0, 11));
            nop  = (kind == 0);
            excp = (kind == 1) ? (32'd1 << $urandom_range(0, 31)) : 32'd0;
            d    = int'($urandom_range(1, 3));
            f    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, d)) : 0;
            run_txn(ld, sel, addr, $urandom, nop, excp,
                    int'($urandom_range(0, 3)), d, int'($urandom_range(0, 2)), f);
        end

        // Reset while a request is waiting in REQ.
        run_txn(1'b1, 3'd0, 32'h0000_8000, 32'hCAFE_F00D, 1'b0, 32'd0, 0, 1, 0, 0);
        exmem_mem_r = 1'b1; exmem_alu_res = 32'h0000_9000; exmem_load_sel = 3'd0;
        begin
            req_t rq;
            rq.addr = 32'h0000_9000; rq.wr = 1'b0; rq.strb = 4'd0; rq.wdata = 32'd0;
            req_q.push_back(rq);
        end
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_inputs();
        last_ld = 32'd0;
        repeat (3) tick();

        run_txn(1'b1, 3'd2, 32'h0000_A001, 32'h0000_F300, 1'b0, 32'd0, 1, 2, 1, 0);
        repeat (4) tick();
        check32("req_queue_drained", 32'(req_q.size()), 32'd0);
        check32("result_queue_drained", 32'(res_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
